// File: rtl/osiris_pkg.sv
// Shared Osiris I types: canonical EX->MEM payload layout and skid FSM states.
package osiris_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH  = 5;
  localparam int RSRC_WIDTH = 2;

  // Canonical EX->MEM payload at the core's default widths.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_target;
    logic [REG_WIDTH-1:0]  rd;
    logic                  reg_write;
    logic [RSRC_WIDTH-1:0] result_src;
    logic                  mem_write;
  } ex_mem_payload_t;

  // Occupancy of a 2-entry skid buffer: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_pipe_skid_reg.sv
// skid_reg: payload-agnostic 2-entry skid buffer with flush.
// ready_o comes straight from the state register, so there is no
// combinational path from ready_i back to the producer.
module skid_reg
  import osiris_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, drain;
  logic             load_main_in, load_main_skid, load_skid;

  assign ready_o = (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign data_o  = main_q;
  assign accept  = valid_i & ready_o;
  assign drain   = valid_o & ready_i;

  // Next-state and load enables; flush wins over any handshake.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: if (drain) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers; payload only moves on accept or skid->main.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in)        main_q <= data_i;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= data_i;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: elastic EX->MEM stage register for Osiris I.
// Packs the EX fields into one vector around skid_reg and squashes the
// write enables of bubbles. Optional perf counters: EX_MEM_PERF_CNT_EN.
module ex_mem_pipe
  import osiris_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int RSRC_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid_EX,
  output logic                  o_ready_EX,
  input  logic [DATA_WIDTH-1:0] i_alu_result_EX,
  input  logic [DATA_WIDTH-1:0] i_write_data_EX,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4_EX,
  input  logic [DATA_WIDTH-1:0] i_pc_target_EX,
  input  logic [REG_WIDTH-1:0]  i_rd_EX,
  input  logic                  i_reg_write_EX,
  input  logic [RSRC_WIDTH-1:0] i_result_src_EX,
  input  logic                  i_mem_write_EX,
  input  logic                  i_flush,
  input  logic                  i_ready_M,
  output logic                  o_valid_M,
  output logic [DATA_WIDTH-1:0] o_alu_result_M,
  output logic [DATA_WIDTH-1:0] o_write_data_M,
  output logic [DATA_WIDTH-1:0] o_pc_plus4_M,
  output logic [DATA_WIDTH-1:0] o_pc_target_M,
  output logic [REG_WIDTH-1:0]  o_rd_M,
  output logic                  o_reg_write_M,
  output logic [RSRC_WIDTH-1:0] o_result_src_M,
  output logic                  o_mem_write_M
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cnt,
  output logic [31:0]           o_flush_cnt
`endif
);

  // Same field order as ex_mem_payload_t, but sized by this instance's
  // parameters so non-default widths still work.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_target;
    logic [REG_WIDTH-1:0]  rd;
    logic                  reg_write;
    logic [RSRC_WIDTH-1:0] result_src;
    logic                  mem_write;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t in_pl, out_pl;

  assign in_pl = '{alu_result: i_alu_result_EX, write_data: i_write_data_EX,
                   pc_plus4:   i_pc_plus4_EX,   pc_target:  i_pc_target_EX,
                   rd:         i_rd_EX,         reg_write:  i_reg_write_EX,
                   result_src: i_result_src_EX, mem_write:  i_mem_write_EX};

  skid_reg #(.WIDTH(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .valid_i (i_valid_EX),
    .ready_o (o_ready_EX),
    .data_i  (in_pl),
    .flush_i (i_flush),
    .valid_o (o_valid_M),
    .ready_i (i_ready_M),
    .data_o  (out_pl)
  );

  assign o_alu_result_M = out_pl.alu_result;
  assign o_write_data_M = out_pl.write_data;
  assign o_pc_plus4_M   = out_pl.pc_plus4;
  assign o_pc_target_M  = out_pl.pc_target;
  assign o_rd_M         = out_pl.rd;
  assign o_result_src_M = out_pl.result_src;
  // A bubble must never write the register file or memory.
  assign o_reg_write_M  = out_pl.reg_write & o_valid_M;
  assign o_mem_write_M  = out_pl.mem_write & o_valid_M;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating event counters; a flush only counts if it kills something.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_valid_M && !i_ready_M && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (i_flush && o_valid_M && flush_cnt_q != '1)    flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed vector table, perf-counter sequence
// (when EX_MEM_PERF_CNT_EN is defined) and random traffic vs a queue model.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid_EX, o_ready_EX;
  logic [31:0] i_alu_result_EX, i_write_data_EX, i_pc_plus4_EX, i_pc_target_EX;
  logic [4:0]  i_rd_EX;
  logic        i_reg_write_EX;
  logic [1:0]  i_result_src_EX;
  logic        i_mem_write_EX;
  logic        i_flush, i_ready_M, o_valid_M;
  logic [31:0] o_alu_result_M, o_write_data_M, o_pc_plus4_M, o_pc_target_M;
  logic [4:0]  o_rd_M;
  logic        o_reg_write_M;
  logic [1:0]  o_result_src_M;
  logic        o_mem_write_M;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst),
    .i_valid_EX(i_valid_EX), .o_ready_EX(o_ready_EX),
    .i_alu_result_EX(i_alu_result_EX), .i_write_data_EX(i_write_data_EX),
    .i_pc_plus4_EX(i_pc_plus4_EX), .i_pc_target_EX(i_pc_target_EX),
    .i_rd_EX(i_rd_EX), .i_reg_write_EX(i_reg_write_EX),
    .i_result_src_EX(i_result_src_EX), .i_mem_write_EX(i_mem_write_EX),
    .i_flush(i_flush), .i_ready_M(i_ready_M), .o_valid_M(o_valid_M),
    .o_alu_result_M(o_alu_result_M), .o_write_data_M(o_write_data_M),
    .o_pc_plus4_M(o_pc_plus4_M), .o_pc_target_M(o_pc_target_M),
    .o_rd_M(o_rd_M), .o_reg_write_M(o_reg_write_M),
    .o_result_src_M(o_result_src_M), .o_mem_write_M(o_mem_write_M)
`ifdef EX_MEM_PERF_CNT_EN
    , .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] alu, wd, pc4, tgt;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
  } ent_t;

  ent_t model_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input ent_t e, input logic fl, input logic rm);
    rst = r; i_valid_EX = v; i_flush = fl; i_ready_M = rm;
    i_alu_result_EX = e.alu; i_write_data_EX = e.wd; i_pc_plus4_EX = e.pc4;
    i_pc_target_EX = e.tgt; i_rd_EX = e.rd; i_reg_write_EX = e.rw;
    i_result_src_EX = e.rs; i_mem_write_EX = e.mw;
  endtask

  // Directed entries derive every field from the ALU value.
  function automatic ent_t mk(input logic [31:0] a, input logic rw, input logic mw);
    ent_t e;
    e.alu = a; e.wd = ~a; e.pc4 = a + 32'd4; e.tgt = a << 1;
    e.rd = a[4:0]; e.rw = rw; e.rs = a[1:0]; e.mw = mw;
    return e;
  endfunction

  task automatic chk_payload(input string tag, input ent_t e);
    chk({tag, ".alu"}, {32'd0, o_alu_result_M}, {32'd0, e.alu});
    chk({tag, ".wd"},  {32'd0, o_write_data_M}, {32'd0, e.wd});
    chk({tag, ".pc4"}, {32'd0, o_pc_plus4_M},   {32'd0, e.pc4});
    chk({tag, ".tgt"}, {32'd0, o_pc_target_M},  {32'd0, e.tgt});
    chk({tag, ".rd"},  {59'd0, o_rd_M},         {59'd0, e.rd});
    chk({tag, ".rs"},  {62'd0, o_result_src_M}, {62'd0, e.rs});
  endtask

  typedef struct {
    logic        r, v, fl, rm, rw, mw;
    logic [31:0] alu;
    logic        xv, xr, xrw, xmw, zero;
    logic [31:0] xalu;
    logic        xalu_rw, xalu_mw;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t row(input logic r, v, fl, rm, rw, mw, input logic [31:0] alu,
                               input logic xv, xr, xrw, xmw, zero, input logic [31:0] xalu,
                               input logic xalu_rw, xalu_mw);
    vec_t t;
    t.r = r; t.v = v; t.fl = fl; t.rm = rm; t.rw = rw; t.mw = mw; t.alu = alu;
    t.xv = xv; t.xr = xr; t.xrw = xrw; t.xmw = xmw; t.zero = zero; t.xalu = xalu;
    t.xalu_rw = xalu_rw; t.xalu_mw = xalu_mw;
    return t;
  endfunction

  initial begin
    ent_t e;
    drive(1'b1, 1'b0, mk(32'd0, 1'b0, 1'b0), 1'b0, 1'b0);

    //            r  v  fl rm rw mw alu      xv xr xrw xmw zero xalu  (payload flags of xalu)
    tbl[0]  = row(1, 1, 0, 1, 1, 1, 32'hAA, 0, 1, 0, 0, 1, 32'h0, 0, 0); // reset
    tbl[1]  = row(1, 1, 0, 1, 1, 1, 32'hAA, 0, 1, 0, 0, 1, 32'h0, 0, 0);
    tbl[2]  = row(0, 1, 0, 1, 0, 0, 32'h10, 1, 1, 0, 0, 0, 32'h10, 0, 0); // streaming
    tbl[3]  = row(0, 1, 0, 1, 0, 0, 32'h20, 1, 1, 0, 0, 0, 32'h20, 0, 0);
    tbl[4]  = row(0, 1, 0, 1, 0, 0, 32'h30, 1, 1, 0, 0, 0, 32'h30, 0, 0);
    tbl[5]  = row(0, 0, 0, 1, 0, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0, 0, 0);
    tbl[6]  = row(0, 1, 0, 0, 0, 0, 32'h1,  1, 1, 0, 0, 0, 32'h1, 0, 0); // backpressure
    tbl[7]  = row(0, 1, 0, 0, 0, 0, 32'h2,  1, 0, 0, 0, 0, 32'h1, 0, 0);
    tbl[8]  = row(0, 1, 0, 0, 0, 0, 32'h3,  1, 0, 0, 0, 0, 32'h1, 0, 0);
    tbl[9]  = row(0, 0, 0, 1, 0, 0, 32'h0,  1, 1, 0, 0, 0, 32'h2, 0, 0);
    tbl[10] = row(0, 0, 0, 1, 0, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0, 0, 0);
    tbl[11] = row(0, 1, 0, 0, 1, 1, 32'h4,  1, 1, 1, 1, 0, 32'h4, 1, 1); // fill FULL
    tbl[12] = row(0, 1, 0, 0, 1, 1, 32'h5,  1, 0, 1, 1, 0, 32'h4, 1, 1);
    tbl[13] = row(0, 1, 1, 0, 1, 1, 32'h6,  0, 1, 0, 0, 0, 32'h0, 0, 0); // flush FULL
    tbl[14] = row(0, 0, 0, 1, 0, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0, 0, 0); // stale rw squashed
    tbl[15] = row(0, 1, 0, 0, 0, 0, 32'h7,  1, 1, 0, 0, 0, 32'h7, 0, 0);
    tbl[16] = row(0, 1, 1, 0, 0, 0, 32'h8,  0, 1, 0, 0, 0, 32'h0, 0, 0); // flush beats accept
    tbl[17] = row(0, 0, 0, 1, 0, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].v, mk(tbl[i].alu, tbl[i].rw, tbl[i].mw), tbl[i].fl, tbl[i].rm);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.valid", i), {63'd0, o_valid_M}, {63'd0, tbl[i].xv});
      chk($sformatf("tbl%0d.ready", i), {63'd0, o_ready_EX}, {63'd0, tbl[i].xr});
      chk($sformatf("tbl%0d.rw", i), {63'd0, o_reg_write_M}, {63'd0, tbl[i].xrw});
      chk($sformatf("tbl%0d.mw", i), {63'd0, o_mem_write_M}, {63'd0, tbl[i].xmw});
      if (tbl[i].zero) begin
        e.alu = 0; e.wd = 0; e.pc4 = 0; e.tgt = 0; e.rd = 0; e.rw = 0; e.rs = 0; e.mw = 0;
        chk_payload($sformatf("tbl%0d.rst", i), e);
      end else if (tbl[i].xv) begin
        chk_payload($sformatf("tbl%0d", i), mk(tbl[i].xalu, tbl[i].xalu_rw, tbl[i].xalu_mw));
      end
    end

`ifdef EX_MEM_PERF_CNT_EN
    // Perf counters: 5 stalled cycles, then one flush of a live entry.
    @(negedge clk); drive(1'b1, 1'b0, mk(32'h0, 0, 0), 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, mk(32'h9, 0, 0), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(1'b0, 1'b0, mk(32'h0, 0, 0), 1'b0, 1'b0);
    end
    @(negedge clk); drive(1'b0, 1'b0, mk(32'h0, 0, 0), 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("perf.stall", {32'd0, o_stall_cnt}, 64'd5);
    chk("perf.flush", {32'd0, o_flush_cnt}, 64'd1);
`endif

    // Random traffic against a FIFO model of at most two entries.
    @(negedge clk); drive(1'b1, 1'b0, mk(32'h0, 0, 0), 1'b0, 1'b0);
    model_q.delete();
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      logic r, v, fl, rm, acc, drn;
      @(negedge clk);
      r  = ($urandom_range(0, 59) == 0);
      fl = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 9) < 6);
      rm = ($urandom_range(0, 9) < 6);
      e.alu = $urandom; e.wd = $urandom; e.pc4 = $urandom; e.tgt = $urandom;
      e.rd = 5'($urandom); e.rw = 1'($urandom); e.rs = 2'($urandom); e.mw = 1'($urandom);
      drive(r, v, e, fl, rm);
      if (r || fl) begin
        model_q.delete();
      end else begin
        acc = v && (model_q.size() < 2);
        drn = rm && (model_q.size() > 0);
        if (drn) void'(model_q.pop_front());
        if (acc) model_q.push_back(e);
      end
      @(posedge clk); #1;
      chk("rnd.valid", {63'd0, o_valid_M}, {63'd0, model_q.size() > 0});
      chk("rnd.ready", {63'd0, o_ready_EX}, {63'd0, model_q.size() < 2});
      if (model_q.size() > 0) begin
        chk_payload("rnd", model_q[0]);
        chk("rnd.rw", {63'd0, o_reg_write_M}, {63'd0, model_q[0].rw});
        chk("rnd.mw", {63'd0, o_mem_write_M}, {63'd0, model_q[0].mw});
      end else begin
        chk("rnd.rw_sq", {63'd0, o_reg_write_M}, 64'd0);
        chk("rnd.mw_sq", {63'd0, o_mem_write_M}, 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised elastic EX->MEM pipeline register. It replaces the plain always-load stage register with a valid/ready handshake, a 2-entry skid buffer, flush and bubble squashing.
- Sits between the execute and memory stages of the Osiris I core.
- Lets the MEM stage back-pressure (e.g. a slow data memory) without a combinational ready path into EX.

Parameters:
- DATA_WIDTH, 32, width of ALU result, store data, PC+4 and PC target.
- REG_WIDTH, 5, register-index width of rd.
- RSRC_WIDTH, 2, width of the result-source select.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid_EX  in  1  EX presents a valid instruction.
- o_ready_EX  out  1  stage can accept; registered.
- i_alu_result_EX  in  DATA_WIDTH  ALU result.
- i_write_data_EX  in  DATA_WIDTH  store data.
- i_pc_plus4_EX  in  DATA_WIDTH  PC+4.
- i_pc_target_EX  in  DATA_WIDTH  branch/jump target.
- i_rd_EX  in  REG_WIDTH  destination register.
- i_reg_write_EX  in  1  register-write enable.
- i_result_src_EX  in  RSRC_WIDTH  writeback mux select.
- i_mem_write_EX  in  1  memory-write enable.
- i_flush  in  1  kill all held entries.
- i_ready_M  in  1  MEM consumes the current entry.
- o_valid_M  out  1  output entry valid.
- o_alu_result_M, o_write_data_M, o_pc_plus4_M, o_pc_target_M  out  DATA_WIDTH  each; registered payload.
- o_rd_M  out  REG_WIDTH  registered.
- o_reg_write_M  out  1  squashed to 0 when !o_valid_M.
- o_result_src_M  out  RSRC_WIDTH  registered.
- o_mem_write_M  out  1  squashed to 0 when !o_valid_M.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. In reset: both valid bits 0, all payload registers 0, o_ready_EX=1, o_valid_M=0.
- Handshake:
  - Accept = i_valid_EX & o_ready_EX.
  - Drain = o_valid_M & i_ready_M.
  - Payload is stable while o_valid_M & !i_ready_M.
- Storage: main register (drives outputs) plus one skid register. o_ready_EX = !skid_valid, registered, with no combinational path from i_ready_M.
- FSM states: EMPTY, ONE (main only), FULL (main+skid).
  - EMPTY: accept -> ONE, data into main.
  - ONE:
    - accept & drain -> ONE, main loaded from input.
    - accept & !drain -> FULL, input into skid.
    - drain & !accept -> EMPTY.
    - neither -> ONE, hold.
  - FULL (o_ready_EX=0, no accept possible):
    - drain -> ONE, main<=skid.
    - else hold.
- Latency: 1 cycle in EMPTY/ONE with i_ready_M=1. Throughput is 1 per cycle under continuous ready.
- Flush:
  - i_flush=1 clears both valid bits next cycle (-> EMPTY).
  - Flush beats a simultaneous accept: the incoming instruction is dropped.
  - Payload registers are not cleared.
  - Priority: rst > i_flush > handshake.
- Squash: o_reg_write_M and o_mem_write_M are ANDed with o_valid_M, so a bubble never writes the register file or memory. Other outputs are don't-care while invalid.
- Ordering: strict FIFO. A skid entry is never overtaken.
- X-safety: payload registers load only on accept or skid move.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- With the macro defined, two extra outputs:
  - o_stall_cnt (32 bits): increments each cycle with o_valid_M & !i_ready_M.
  - o_flush_cnt (32 bits): increments each cycle i_flush kills at least one valid entry.
  - Both counters saturate at all-ones and clear on rst.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package osiris_pkg: the ex_mem_payload_t packed struct (alu_result, write_data, pc_plus4, pc_target, rd, reg_write, result_src, mem_write) and the FSM state enum (EMPTY/ONE/FULL).
- Sub-module skid_reg: generic payload-agnostic 2-entry skid buffer parametrised by WIDTH. ex_mem_pipe packs and unpacks the struct around it and applies the squash.

Test Plan:
- Reset: hold rst 2 cycles with i_valid_EX=1 -> o_valid_M=0, o_ready_EX=1, all outputs 0.
- Streaming: i_ready_M=1, send alu_result 0x10, 0x20, 0x30 on back-to-back cycles -> each appears on o_alu_result_M one cycle later, in order, o_ready_EX stays 1.
- Backpressure: i_ready_M=0, send A=0x1, B=0x2 -> o_ready_EX=0 after B, o_alu_result_M holds 0x1. Raise i_ready_M -> 0x1 then 0x2 drain in order, with no loss or duplicate.
- Flush: FULL state holding entries with mem_write=1, assert i_flush together with i_valid_EX=1 -> next cycle o_valid_M=0, o_mem_write_M=0, o_ready_EX=1, and the incoming instruction is never output.
- Squash: EMPTY state with stale reg_write=1 in the payload -> o_reg_write_M=0 while o_valid_M=0.
- Perf counters (EX_MEM_PERF_CNT_EN): hold o_valid_M with i_ready_M=0 for 5 cycles, then one flush of a valid entry -> o_stall_cnt=5, o_flush_cnt=1.
